// File: rtl/playback_scheduler_pkg.sv
// Shared constants and state encoding for the playback scheduler.
// Optional feature macro: NOTE_GAP_EN (adds the GAP state between notes).
package playback_scheduler_pkg;
  localparam int SONG_BITS_D     = 3;
  localparam int NUM_SONGS_D     = 4;
  localparam int SONG_CNT_BITS_D = 8;
  localparam int GAP_CYCLES_D    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_GAP   = 3'd4
  } state_t;
endpackage

// File: rtl/playback_scheduler_rise_detect.sv
// Registered rising-edge detector: o_rise = i_sig & ~previous(i_sig).
module playback_scheduler_rise_detect
  import playback_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_q;
endmodule

// File: rtl/playback_scheduler.sv
// Song/note sequencer driving the Song ROM and gating the Sound engine.
// Define NOTE_GAP_EN to insert GAP_CYCLES of silence between notes of a song.
module playback_scheduler
  import playback_scheduler_pkg::*;
#(
  parameter int SONG_BITS     = SONG_BITS_D,
  parameter int NUM_SONGS     = NUM_SONGS_D,
  parameter int SONG_CNT_BITS = SONG_CNT_BITS_D,
  parameter int GAP_CYCLES    = GAP_CYCLES_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     play,
  input  logic                     pause_btn,
  input  logic                     next_btn,
  input  logic                     prev_btn,
  input  logic                     loop_all,
  input  logic [SONG_BITS-1:0]     song_sel,
  input  logic [SONG_CNT_BITS-1:0] track,
  input  logic                     over,
  output logic [SONG_BITS-1:0]     song_idx,
  output logic [SONG_CNT_BITS-1:0] note_idx,
  output logic                     snd_en,
  output logic                     playing,
  output logic                     paused,
  output logic                     song_done
);
  localparam logic [SONG_BITS-1:0] NO_SONG   = '1;
  localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);

  if (NUM_SONGS < 1 || NUM_SONGS >= (1 << SONG_BITS)) begin : g_bad_songs
    $error("NUM_SONGS must be in 1..2**SONG_BITS-1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1");
  end

  state_t                   r_state, w_nxt_state;
  logic [SONG_BITS-1:0]     r_song, w_nxt_song;
  logic [SONG_CNT_BITS-1:0] r_note, w_nxt_note;
  logic                     r_done, w_nxt_done;
  logic                     w_over_rise;

`ifdef NOTE_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  logic [GAP_W-1:0] r_gap, w_nxt_gap;
`endif

  // Song arithmetic wraps over the populated songs, not the full index space.
  function automatic logic [SONG_BITS-1:0] f_inc(input logic [SONG_BITS-1:0] s);
    return (s == LAST_SONG) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [SONG_BITS-1:0] f_dec(input logic [SONG_BITS-1:0] s);
    return (s == '0) ? LAST_SONG : s - 1'b1;
  endfunction

  playback_scheduler_rise_detect u_over_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (over),
    .o_rise (w_over_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_song  <= '0;
      r_note  <= '0;
      r_done  <= 1'b0;
`ifdef NOTE_GAP_EN
      r_gap   <= '0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_song  <= w_nxt_song;
      r_note  <= w_nxt_note;
      r_done  <= w_nxt_done;
`ifdef NOTE_GAP_EN
      r_gap   <= w_nxt_gap;
`endif
    end
  end

  // Event priority inside PLAY/PAUSE/GAP: prev > next > over edge > pause.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_song  = r_song;
    w_nxt_note  = r_note;
    w_nxt_done  = 1'b0;
`ifdef NOTE_GAP_EN
    w_nxt_gap   = r_gap;
`endif
    case (r_state)
      ST_IDLE: begin
        w_nxt_song = song_sel;
        w_nxt_note = '0;
        if (play && song_sel != NO_SONG && song_sel <= LAST_SONG) w_nxt_state = ST_LOAD;
      end
      ST_LOAD: w_nxt_state = ST_PLAY;
      default: begin
        if (prev_btn) begin
          if (r_note == '0) w_nxt_song = f_dec(r_song);
          w_nxt_note  = '0;
          w_nxt_state = ST_LOAD;
        end else if (next_btn) begin
          w_nxt_song  = f_inc(r_song);
          w_nxt_note  = '0;
          w_nxt_state = ST_LOAD;
        end else if (r_state == ST_PLAY && w_over_rise) begin
          if (r_note < track) begin
            w_nxt_note = r_note + 1'b1;
`ifdef NOTE_GAP_EN
            w_nxt_state = ST_GAP;
            w_nxt_gap   = GAP_W'(GAP_CYCLES - 1);
`endif
          end else begin
            w_nxt_done = 1'b1;
            w_nxt_note = '0;
            if (loop_all) begin
              w_nxt_song  = f_inc(r_song);
              w_nxt_state = ST_LOAD;
            end else begin
              w_nxt_state = ST_IDLE;
            end
          end
        end else if (pause_btn) begin
          // Resume goes through LOAD so the engine restarts the held note.
          w_nxt_state = (r_state == ST_PAUSE) ? ST_LOAD : ST_PAUSE;
`ifdef NOTE_GAP_EN
        end else if (r_state == ST_GAP) begin
          if (r_gap == '0) w_nxt_state = ST_PLAY;
          else             w_nxt_gap   = r_gap - 1'b1;
`endif
        end
      end
    endcase
    if (!play && r_state != ST_IDLE) begin
      w_nxt_state = ST_IDLE;
      w_nxt_song  = r_song;
      w_nxt_note  = '0;
      w_nxt_done  = 1'b0;
    end
  end

  always_comb begin
    snd_en  = 1'b0;
    playing = 1'b0;
    paused  = 1'b0;
    case (r_state)
      ST_PLAY:  begin snd_en = 1'b1; playing = 1'b1; end
      ST_GAP:   playing = 1'b1;
      ST_PAUSE: paused = 1'b1;
      default:  ;
    endcase
  end

  assign song_idx  = r_song;
  assign note_idx  = r_note;
  assign song_done = r_done;
endmodule

// File: tb/tb_playback_scheduler.sv
// Directed, table-driven bench for playback_scheduler (default config; NOTE_GAP_EN adds a gap check).
module tb_playback_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play = 1'b0, pause_btn = 1'b0, next_btn = 1'b0, prev_btn = 1'b0;
  logic       loop_all = 1'b0, over = 1'b0;
  logic [2:0] song_sel = '0;
  logic [7:0] track = '0;
  logic [2:0] song_idx;
  logic [7:0] note_idx;
  logic       snd_en, playing, paused, song_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  playback_scheduler dut (
    .clk(clk), .rst_n(rst_n), .play(play), .pause_btn(pause_btn),
    .next_btn(next_btn), .prev_btn(prev_btn), .loop_all(loop_all),
    .song_sel(song_sel), .track(track), .over(over),
    .song_idx(song_idx), .note_idx(note_idx), .snd_en(snd_en),
    .playing(playing), .paused(paused), .song_done(song_done)
  );

  typedef struct {
    logic       play, pause_b, next_b, prev_b, loop_all, over;
    logic [2:0] sel;
    logic [7:0] track;
    logic [13:0] exp;
  } vec_t;

  vec_t tv[$];

  // Expected output word: {song_idx, note_idx, snd_en, playing, paused, song_done}
  function automatic logic [13:0] ex(input int s, input int n, input int f);
    logic [2:0] s3; logic [7:0] n8; logic [3:0] f4;
    s3 = s[2:0]; n8 = n[7:0]; f4 = f[3:0];
    return {s3, n8, f4};
  endfunction

  function automatic logic [13:0] outs();
    return {song_idx, note_idx, snd_en, playing, paused, song_done};
  endfunction

  function automatic vec_t mk(input int pl, input int pa, input int nx, input int pv,
                              input int lp, input int sel, input int trk, input int ov,
                              input int es, input int en, input int ef);
    vec_t v;
    v.play = pl[0]; v.pause_b = pa[0]; v.next_b = nx[0]; v.prev_b = pv[0];
    v.loop_all = lp[0]; v.over = ov[0]; v.sel = sel[2:0]; v.track = trk[7:0];
    v.exp = ex(es, en, ef);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h (song,note,flags) want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // flags column: 4'b{snd_en,playing,paused,song_done}
    //         pl pa nx pv lp sel trk ov   song note flags
    tv.push_back(mk(1,0,0,0,0, 1, 3, 0,   1, 0, 4'b0000)); // IDLE->LOAD
    tv.push_back(mk(1,0,0,0,0, 1, 3, 0,   1, 0, 4'b1100)); // LOAD->PLAY
    tv.push_back(mk(1,0,0,0,0, 1, 3, 1,   1, 1, 4'b1100));
    tv.push_back(mk(1,0,0,0,0, 1, 3, 0,   1, 1, 4'b1100));
    tv.push_back(mk(1,0,0,0,0, 1, 3, 1,   1, 2, 4'b1100));
    tv.push_back(mk(1,0,0,0,0, 1, 3, 0,   1, 2, 4'b1100));
    tv.push_back(mk(1,0,0,0,0, 1, 3, 1,   1, 3, 4'b1100));
    tv.push_back(mk(1,0,0,0,0, 1, 3, 0,   1, 3, 4'b1100));
    tv.push_back(mk(1,0,0,0,0, 1, 3, 1,   1, 0, 4'b0001)); // last note: done, IDLE
    tv.push_back(mk(0,0,0,0,0, 1, 3, 0,   1, 0, 4'b0000));
    tv.push_back(mk(1,0,0,0,1, 3, 0, 0,   3, 0, 4'b0000)); // start song 3, loop
    tv.push_back(mk(1,0,0,0,1, 3, 0, 0,   3, 0, 4'b1100));
    tv.push_back(mk(1,0,0,0,1, 3, 0, 1,   0, 0, 4'b0001)); // wrap 3->0, LOAD
    tv.push_back(mk(1,0,0,0,1, 3, 5, 0,   0, 0, 4'b1100));
    tv.push_back(mk(1,0,0,0,1, 3, 5, 1,   0, 1, 4'b1100));
    tv.push_back(mk(1,0,0,0,1, 3, 5, 0,   0, 1, 4'b1100));
    tv.push_back(mk(1,0,0,0,1, 3, 5, 1,   0, 2, 4'b1100));
    tv.push_back(mk(1,0,0,0,1, 3, 5, 0,   0, 2, 4'b1100));
    tv.push_back(mk(1,0,0,1,1, 3, 5, 0,   0, 0, 4'b0000)); // prev: restart song
    tv.push_back(mk(1,0,0,0,1, 3, 5, 0,   0, 0, 4'b1100));
    tv.push_back(mk(1,0,0,1,1, 3, 5, 0,   3, 0, 4'b0000)); // prev at note 0: 0->3
    tv.push_back(mk(1,0,0,0,1, 3, 5, 0,   3, 0, 4'b1100));
    tv.push_back(mk(1,0,1,0,1, 3, 5, 1,   0, 0, 4'b0000)); // next beats over
    tv.push_back(mk(1,0,0,0,1, 3, 5, 0,   0, 0, 4'b1100));
    tv.push_back(mk(1,0,0,0,1, 3, 5, 1,   0, 1, 4'b1100));
    tv.push_back(mk(0,0,0,0,1, 3, 5, 0,   0, 0, 4'b0000)); // play=0 abort
    tv.push_back(mk(0,0,0,0,1, 2, 5, 0,   2, 0, 4'b0000));
    tv.push_back(mk(1,0,0,0,1, 7, 5, 0,   7, 0, 4'b0000)); // NO_SONG: stay IDLE
    tv.push_back(mk(1,0,0,0,1, 4, 5, 0,   4, 0, 4'b0000)); // >= NUM_SONGS
    tv.push_back(mk(1,0,0,0,1, 2, 5, 0,   2, 0, 4'b0000));
    tv.push_back(mk(1,0,0,0,1, 2, 5, 0,   2, 0, 4'b1100));
    tv.push_back(mk(1,0,0,0,1, 2, 5, 1,   2, 1, 4'b1100));
    tv.push_back(mk(1,0,0,0,1, 2, 5, 0,   2, 1, 4'b1100));
    tv.push_back(mk(1,0,1,1,1, 2, 5, 0,   2, 0, 4'b0000)); // prev beats next
    tv.push_back(mk(1,0,0,0,1, 2, 5, 0,   2, 0, 4'b1100));
    tv.push_back(mk(1,0,1,1,1, 2, 5, 0,   1, 0, 4'b0000));
    tv.push_back(mk(1,0,0,0,1, 2, 5, 0,   1, 0, 4'b1100));
    tv.push_back(mk(1,0,1,0,1, 2, 5, 0,   2, 0, 4'b0000));
    tv.push_back(mk(1,1,0,0,1, 2, 5, 0,   2, 0, 4'b1100)); // pause in LOAD ignored
    tv.push_back(mk(1,0,1,0,1, 2, 5, 0,   3, 0, 4'b0000));
    tv.push_back(mk(1,0,0,0,1, 2, 5, 0,   3, 0, 4'b1100));
    tv.push_back(mk(1,1,0,0,1, 2, 5, 1,   3, 1, 4'b1100)); // over beats pause
    tv.push_back(mk(1,0,0,0,1, 2, 5, 0,   3, 1, 4'b1100));
    tv.push_back(mk(1,1,0,0,1, 2, 5, 0,   3, 1, 4'b0010)); // pause
    tv.push_back(mk(1,0,0,0,1, 2, 5, 0,   3, 1, 4'b0010));
    tv.push_back(mk(1,0,1,0,1, 2, 5, 0,   0, 0, 4'b0000)); // next clears pause
    tv.push_back(mk(1,0,0,0,1, 2, 5, 0,   0, 0, 4'b1100));

    #3;
    chk("reset_state", outs(), ex(0, 0, 0));
    #9;
    rst_n = 1'b1;

`ifdef NOTE_GAP_EN
    begin
      int lows;
      play = 1'b1; song_sel = 3'd0; track = 8'd3; loop_all = 1'b0;
      tick(); tick();
      chk("gap_start_play", outs(), ex(0, 0, 4'b1100));
      over = 1'b1; tick(); over = 1'b0;
      chk("gap_enter", outs(), ex(0, 1, 4'b0100));
      lows = 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (snd_en) break;
        lows++;
      end
      chk_int("gap_len", lows, 16);
      chk("gap_exit", outs(), ex(0, 1, 4'b1100));
    end
`else
    for (int i = 0; i < tv.size(); i++) begin
      play = tv[i].play; pause_btn = tv[i].pause_b; next_btn = tv[i].next_b;
      prev_btn = tv[i].prev_b; loop_all = tv[i].loop_all; over = tv[i].over;
      song_sel = tv[i].sel; track = tv[i].track;
      tick();
      chk($sformatf("vec%0d", i), outs(), tv[i].exp);
    end
    pause_btn = 1'b0; next_btn = 1'b0; prev_btn = 1'b0; over = 1'b0;

    // Walk to note 5; final over held high must advance only once.
    track = 8'd7;
    for (int k = 1; k <= 4; k++) begin
      over = 1'b1; tick();
      chk($sformatf("walk%0d", k), outs(), ex(0, k, 4'b1100));
      over = 1'b0; tick();
    end
    over = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("over_level%0d", k), outs(), ex(0, 5, 4'b1100));
    end
    over = 1'b0; tick();

    pause_btn = 1'b1; tick(); pause_btn = 1'b0;
    chk("pause_enter", outs(), ex(0, 5, 4'b0010));
    for (int c = 0; c < 100; c++) begin
      over = (c == 50);
      tick();
      chk($sformatf("pause_hold%0d", c), outs(), ex(0, 5, 4'b0010));
    end
    over = 1'b0;
    pause_btn = 1'b1; tick(); pause_btn = 1'b0;
    chk("resume_load", outs(), ex(0, 5, 4'b0000));
    tick();
    chk("resume_play", outs(), ex(0, 5, 4'b1100));

    // Asynchronous reset mid-note, away from any clock edge.
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), ex(0, 0, 0));
    play = 1'b0; song_sel = 3'd2;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_reset_idle", outs(), ex(2, 0, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
